// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_AUX  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                          we;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side port of the data-memory arbiter: request fields, grant and read response.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = dmem_arb_pkg::DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = dmem_arb_pkg::DEFAULT_DATA_WIDTH
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arb_select.sv
// Combinational grant selector: fixed core>aux priority, or round-robin with a
// last-winner pointer when DMEM_ARB_ROUND_ROBIN_EN is defined.
module dmem_arb_select
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  owner_e last_winner,
  output owner_e last_winner_nxt,
`endif
  input  logic   core_req,
  input  logic   aux_req,
  output logic   core_gnt,
  output logic   aux_gnt
);

  always_comb begin
    core_gnt = 1'b0;
    aux_gnt  = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_winner_nxt = last_winner;
    // On contention the port that did not win most recently goes first
    if (core_req && aux_req) begin
      if (last_winner == OWNER_AUX) core_gnt = 1'b1;
      else                          aux_gnt  = 1'b1;
    end else begin
      core_gnt = core_req;
      aux_gnt  = aux_req;
    end
    if (core_gnt)     last_winner_nxt = OWNER_CORE;
    else if (aux_gnt) last_winner_nxt = OWNER_AUX;
`else
    core_gnt = core_req;
    aux_gnt  = aux_req & ~core_req;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory: accept, access, response.
// Optional round-robin arbitration under DMEM_ARB_ROUND_ROBIN_EN (default: fixed core>aux).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         core,
  dmem_arbiter_if.slave         aux,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  logic                  core_gnt_c;
  logic                  aux_gnt_c;
  logic                  accept_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;

  owner_e                owner_q;
  logic                  core_rvalid_q;
  logic                  aux_rvalid_q;
  logic [DATA_WIDTH-1:0] core_rdata_q;
  logic [DATA_WIDTH-1:0] aux_rdata_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  owner_e last_winner_q;
  owner_e last_winner_nxt_c;

  // Reset to "aux won last" so the core wins the first contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_winner_q <= OWNER_AUX;
    else      last_winner_q <= last_winner_nxt_c;
  end
`endif

  dmem_arb_select u_select (
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .last_winner     (last_winner_q),
    .last_winner_nxt (last_winner_nxt_c),
`endif
    .core_req        (core.req),
    .aux_req         (aux.req),
    .core_gnt        (core_gnt_c),
    .aux_gnt         (aux_gnt_c)
  );

  // Mux the winning request into the stage-1 inputs
  always_comb begin
    accept_c    = core_gnt_c | aux_gnt_c;
    sel_we_c    = core.we;
    sel_addr_c  = core.addr;
    sel_wdata_c = core.wdata;
    if (aux_gnt_c) begin
      sel_we_c    = aux.we;
      sel_addr_c  = aux.addr;
      sel_wdata_c = aux.wdata;
    end
  end

  // Stage 1: strobes pulse only for an accepted request; address/data hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      owner_q        <= OWNER_CORE;
    end else begin
      mem_read  <= accept_c & ~sel_we_c;
      mem_write <= accept_c &  sel_we_c;
      if (accept_c) begin
        mem_address    <= sel_addr_c;
        mem_write_data <= sel_wdata_c;
        owner_q        <= aux_gnt_c ? OWNER_AUX : OWNER_CORE;
      end
    end
  end

  // Stage 2: capture read data for the owning port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid_q <= 1'b0;
      aux_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      aux_rdata_q   <= '0;
    end else begin
      core_rvalid_q <= mem_read & (owner_q == OWNER_CORE);
      aux_rvalid_q  <= mem_read & (owner_q == OWNER_AUX);
      if (mem_read && owner_q == OWNER_CORE) core_rdata_q <= mem_read_data;
      if (mem_read && owner_q == OWNER_AUX)  aux_rdata_q  <= mem_read_data;
    end
  end

  assign core.gnt    = core_gnt_c;
  assign core.rvalid = core_rvalid_q;
  assign core.rdata  = core_rdata_q;
  assign aux.gnt     = aux_gnt_c;
  assign aux.rvalid  = aux_rvalid_q;
  assign aux.rdata   = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 16x32 data memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam bit CORE = 1'b0;
  localparam bit AUX  = 1'b1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read, mem_write;
  logic [3:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic [31:0] mem [16];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  exp_t sq[$];
  exp_t cq[$];
  exp_t aq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if core_if ();
  dmem_arbiter_if aux_if ();

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .core           (core_if),
    .aux            (aux_if),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: combinational read, write committed on the rising edge
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic dmem_req_t mk(input logic we, input logic [3:0] a, input logic [31:0] d);
    dmem_req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // Raise a request, wait for its grant, queue the expected strobe and read response
  task automatic issue(input bit port, input dmem_req_t r, input logic [31:0] exp_rd, output int g);
    int   budget;
    logic gnt;
    budget = 20;
    g = -1;
    if (port == AUX) begin
      aux_if.req = 1'b1; aux_if.we = r.we; aux_if.addr = r.addr; aux_if.wdata = r.wdata;
    end else begin
      core_if.req = 1'b1; core_if.we = r.we; core_if.addr = r.addr; core_if.wdata = r.wdata;
    end
    @(negedge clk);
    gnt = (port == AUX) ? aux_if.gnt : core_if.gnt;
    while (!gnt && budget > 0) begin
      @(negedge clk);
      gnt = (port == AUX) ? aux_if.gnt : core_if.gnt;
      budget--;
    end
    if (!gnt) begin
      flag(port == AUX ? "aux_gnt_timeout" : "core_gnt_timeout");
    end else begin
      g = cyc;
      sq.push_back('{cyc: cyc + 1, we: r.we, addr: r.addr, data: r.wdata});
      if (!r.we) begin
        if (port == AUX) aq.push_back('{cyc: cyc + 2, we: 1'b0, addr: r.addr, data: exp_rd});
        else             cq.push_back('{cyc: cyc + 2, we: 1'b0, addr: r.addr, data: exp_rd});
      end
    end
    @(posedge clk);
    #1;
    if (port == AUX) aux_if.req = 1'b0;
    else             core_if.req = 1'b0;
  endtask

  // Monitor: grant legality, memory strobes and read responses against the queues
  always @(negedge clk) begin
    exp_t e;
    if (core_if.gnt || aux_if.gnt) begin
      chk("gnt_onehot", 32'(core_if.gnt & aux_if.gnt), 32'd0);
      chk("gnt_without_req", 32'((core_if.gnt & ~core_if.req) | (aux_if.gnt & ~aux_if.req)), 32'd0);
`ifndef DMEM_ARB_ROUND_ROBIN_EN
      chk("aux_gnt_while_core_req", 32'(aux_if.gnt & core_if.req), 32'd0);
`endif
    end
    if (mem_read || mem_write) begin
      if (sq.size() == 0) flag("mem_strobe_unexpected");
      else begin
        e = sq.pop_front();
        chk("mem_strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("mem_write", 32'(mem_write), 32'(e.we));
        chk("mem_read", 32'(mem_read), 32'(!e.we));
        chk("mem_address", 32'(mem_address), 32'(e.addr));
        if (e.we) chk("mem_write_data", mem_write_data, e.data);
      end
    end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
      flag("mem_strobe_missing");
      void'(sq.pop_front());
    end
    if (core_if.rvalid) begin
      if (cq.size() == 0) flag("core_rvalid_unexpected");
      else begin
        e = cq.pop_front();
        chk("core_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        chk("core_rdata", core_if.rdata, e.data);
      end
    end else if (cq.size() != 0 && cq[0].cyc <= cyc) begin
      flag("core_rvalid_missing");
      void'(cq.pop_front());
    end
    if (aux_if.rvalid) begin
      if (aq.size() == 0) flag("aux_rvalid_unexpected");
      else begin
        e = aq.pop_front();
        chk("aux_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        chk("aux_rdata", aux_if.rdata, e.data);
      end
    end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
      flag("aux_rvalid_missing");
      void'(aq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, rel, g0, g1, g2, g3;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    core_if.req = 1'b0; core_if.we = 1'b0; core_if.addr = 4'd0; core_if.wdata = 32'd0;
    aux_if.req  = 1'b0; aux_if.we  = 1'b0; aux_if.addr  = 4'd0; aux_if.wdata  = 32'd0;

    // Reset held with a pending core request
    core_if.req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_core_rvalid", 32'(core_if.rvalid), 32'd0);
    chk("rst_aux_rvalid", 32'(aux_if.rvalid), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    rel = cyc;
    issue(CORE, mk(1'b0, 4'd0, 32'd0), 32'd0, g);
    chk("first_gnt_cycle", 32'(g), 32'(rel));

    // Core write then back-to-back read of the same address
    issue(CORE, mk(1'b1, 4'd4, 32'hDEADBEEF), 32'd0, g);
    issue(CORE, mk(1'b0, 4'd4, 32'd0), 32'hDEADBEEF, g);

    // Aux alone
    issue(AUX, mk(1'b1, 4'd15, 32'h0000_00A5), 32'd0, g);
    issue(AUX, mk(1'b0, 4'd15, 32'd0), 32'h0000_00A5, g);

    // Cross-port hazard: core write followed by aux read of the same word
    issue(CORE, mk(1'b1, 4'd7, 32'h0BAD_F00D), 32'd0, g);
    issue(AUX, mk(1'b0, 4'd7, 32'd0), 32'h0BAD_F00D, g);
    repeat (3) @(negedge clk);
    chk("core_rdata_hold", core_if.rdata, 32'hDEADBEEF);
    chk("aux_rdata_hold", aux_if.rdata, 32'h0BAD_F00D);

    // Contention: both ports request from the same cycle
    @(posedge clk);
    #1;
    fork
      begin
        issue(CORE, mk(1'b0, 4'd4, 32'd0), 32'hDEADBEEF, g0);
        issue(CORE, mk(1'b0, 4'd15, 32'd0), 32'h0000_00A5, g1);
      end
      begin
        issue(AUX, mk(1'b0, 4'd7, 32'd0), 32'h0BAD_F00D, g2);
        issue(AUX, mk(1'b0, 4'd4, 32'd0), 32'hDEADBEEF, g3);
      end
    join
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    chk("rr_aux_first_gnt", 32'(g2), 32'(g0 + 1));
    chk("rr_core_second_gnt", 32'(g1), 32'(g0 + 2));
    chk("rr_aux_second_gnt", 32'(g3), 32'(g0 + 3));
`else
    chk("fp_core_second_gnt", 32'(g1), 32'(g0 + 1));
    chk("fp_aux_first_gnt", 32'(g2), 32'(g0 + 2));
    chk("fp_aux_second_gnt", 32'(g3), 32'(g0 + 3));
`endif
    repeat (3) @(negedge clk);

    // Reset during the access cycle of a write: no commit, no response afterwards
    @(posedge clk);
    #1;
    issue(CORE, mk(1'b1, 4'd2, 32'h0000_1234), 32'd0, g);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_core_rdata", core_if.rdata, 32'd0);
    chk("midrst_aux_rdata", aux_if.rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(CORE, mk(1'b0, 4'd2, 32'd0), 32'd0, g);
    issue(AUX, mk(1'b0, 4'd4, 32'd0), 32'hDEADBEEF, g);

    repeat (5) @(negedge clk);
    chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
    chk("core_queue_drained", 32'(cq.size()), 32'd0);
    chk("aux_queue_drained", 32'(aq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
